// File: rtl/cipher_iter.sv
// Iterative AES-128 encryption core: one round per clock on a single shared round datapath.
// The final round skips MixColumns and writes the registered ciphertext output.
module cipher_iter #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [0:127]          in_msg,
    input  logic [0:128*(Nr+1)-1] w,
    output logic                  busy,
    output logic                  done,
    output logic [0:127]          enc_msg
);

    // AES runs Nk+6 rounds; never step past that even if Nr is set larger.
    localparam int unsigned Rounds    = (Nr < Nk + 6) ? Nr : Nk + 6;
    localparam logic [3:0]  LastRound = 4'(Rounds);

    localparam logic [0:2047] SboxTbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {StIdle, StRun} state_e;

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] data_q, data_d;
    logic [0:127] enc_q, enc_d;
    logic         done_q, done_d;

    logic [0:127] round_key;
    logic [0:127] shifted;
    logic [0:127] mixed;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTbl[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows commute, so the byte lookup and the row rotation share one loop.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:31] mix_col(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[32*c +: 32] = mix_col(s[32*c +: 32]);
        end
        return o;
    endfunction

    always_comb begin
        round_key = '0;
        for (int unsigned r = 0; r <= Nr; r++) begin
            if (round_q == 4'(r)) begin
                round_key = w[r*128 +: 128];
            end
        end
        shifted = sub_shift(data_q);
        mixed   = mix_columns(shifted);
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        enc_d   = enc_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = in_msg ^ w[0 +: 128];
                    round_d = 4'd1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (round_q != LastRound) begin
                    data_d  = mixed ^ round_key;
                    round_d = round_q + 4'd1;
                end else begin
                    enc_d   = shifted ^ round_key;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            data_q  <= '0;
            enc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            enc_q   <= enc_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = done_q;
    assign enc_msg = enc_q;

endmodule
